// File: rtl/cfi_shadow_stack_backend.sv
// CFI shadow-stack backend.
//
// Drains the fall-through CFI log FIFO one entry every two cycles. Calls push
// their return address onto a hardware shadow stack, returns are checked
// against and pop the top entry, and branches and jumps are consumed without
// any check. A violation parks the block in a sticky fault state until
// software acknowledges it with fault_clear_i.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   queue_empty_i       log FIFO empty
//   log_type_i          head entry type: 00 branch, 01 jump, 10 call, 11 return
//   log_pc_i            head entry instruction PC
//   log_target_i        head entry resolved target
//   log_compressed_i    head entry is a 16-bit instruction
//   queue_pop_o         pop the head entry (combinational, IDLE only)
//   fault_valid_o       sticky violation flag
//   fault_cause_o       01 mismatch, 10 underflow, 11 overflow, 00 none
//   fault_tval_o        PC of the offending instruction
//   fault_clear_i       acknowledge fault and resume
//   stack_level_o       number of valid shadow-stack entries
module cfi_shadow_stack_backend #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           queue_empty_i,
  input  logic [1:0]                     log_type_i,
  input  logic [XLEN-1:0]                log_pc_i,
  input  logic [XLEN-1:0]                log_target_i,
  input  logic                           log_compressed_i,
  output logic                           queue_pop_o,
  output logic                           fault_valid_o,
  output logic [1:0]                     fault_cause_o,
  output logic [XLEN-1:0]                fault_tval_o,
  input  logic                           fault_clear_i,
  output logic [$clog2(STACK_DEPTH):0]   stack_level_o
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned SW = AW + 1;

  localparam logic [1:0] TypeCall   = 2'b10;
  localparam logic [1:0] TypeReturn = 2'b11;

  localparam logic [1:0] CauseNone      = 2'b00;
  localparam logic [1:0] CauseMismatch  = 2'b01;
  localparam logic [1:0] CauseUnderflow = 2'b10;
  localparam logic [1:0] CauseOverflow  = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StFault} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     sp_q, sp_d;
  logic [1:0]        type_q, type_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              comp_q, comp_d;
  logic              fault_valid_q, fault_valid_d;
  logic [1:0]        cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;

  logic [XLEN-1:0]   stack_q [STACK_DEPTH];
  logic              stack_we;
  logic [AW-1:0]     top_idx;
  logic [XLEN-1:0]   stack_top;
  logic [XLEN-1:0]   ret_addr;
  logic              pop;

  // Reset must never consume an entry, so the pop is gated by rst_i.
  assign pop = (state_q == StIdle) && !queue_empty_i && !rst_i;

  // With sp == STACK_DEPTH the low bits are zero, so the subtraction still
  // lands on the last entry.
  assign top_idx   = sp_q[AW-1:0] - AW'(1);
  assign stack_top = stack_q[top_idx];
  // Wraps modulo 2^XLEN by construction.
  assign ret_addr  = pc_q + (comp_q ? XLEN'(2) : XLEN'(4));

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    type_d        = type_q;
    pc_d          = pc_q;
    target_d      = target_q;
    comp_d        = comp_q;
    fault_valid_d = fault_valid_q;
    cause_d       = cause_q;
    tval_d        = tval_q;
    stack_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          type_d   = log_type_i;
          pc_d     = log_pc_i;
          target_d = log_target_i;
          comp_d   = log_compressed_i;
          state_d  = StExec;
        end
      end

      StExec: begin
        state_d = StIdle;
        case (type_q)
          TypeCall: begin
            if (sp_q == SW'(STACK_DEPTH)) begin
              fault_valid_d = 1'b1;
              cause_d       = CauseOverflow;
              tval_d        = pc_q;
              state_d       = StFault;
            end else begin
              stack_we = 1'b1;
              sp_d     = sp_q + SW'(1);
            end
          end
          TypeReturn: begin
            if (sp_q == '0) begin
              fault_valid_d = 1'b1;
              cause_d       = CauseUnderflow;
              tval_d        = pc_q;
              state_d       = StFault;
            end else begin
              // The top entry is consumed whether or not it matches.
              sp_d = sp_q - SW'(1);
              if (stack_top != target_q) begin
                fault_valid_d = 1'b1;
                cause_d       = CauseMismatch;
                tval_d        = pc_q;
                state_d       = StFault;
              end
            end
          end
          default: ;  // branch / jump: consumed without a check
        endcase
      end

      StFault: begin
        if (fault_clear_i) begin
          sp_d          = '0;
          fault_valid_d = 1'b0;
          cause_d       = CauseNone;
          tval_d        = '0;
          state_d       = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      sp_q          <= '0;
      type_q        <= '0;
      pc_q          <= '0;
      target_q      <= '0;
      comp_q        <= 1'b0;
      fault_valid_q <= 1'b0;
      cause_q       <= CauseNone;
      tval_q        <= '0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      type_q        <= type_d;
      pc_q          <= pc_d;
      target_q      <= target_d;
      comp_q        <= comp_d;
      fault_valid_q <= fault_valid_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
    end
  end

  // Stack contents are don't-care after reset; only sp qualifies them.
  always_ff @(posedge clk_i) begin
    if (stack_we) begin
      stack_q[sp_q[AW-1:0]] <= ret_addr;
    end
  end

  assign queue_pop_o   = pop;
  assign fault_valid_o = fault_valid_q;
  assign fault_cause_o = cause_q;
  assign fault_tval_o  = tval_q;
  assign stack_level_o = sp_q;

endmodule

// File: tb/tb_cfi_shadow_stack_backend.sv
// Self-checking bench for cfi_shadow_stack_backend.
// A driver fills a behavioural log FIFO; a model process derives the expected
// pop/fault/level per cycle into a scoreboard queue; a monitor pops and compares.
module tb_cfi_shadow_stack_backend;

  localparam int XLEN  = 64;
  localparam int DEPTH = 16;
  localparam int SW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [1:0]      typ;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            comp;
  } entry_t;

  typedef struct {
    logic            pop;
    logic            valid;
    logic [1:0]      cause;
    logic [XLEN-1:0] tval;
    logic [SW-1:0]   level;
  } exp_t;

  logic            clk;
  logic            rst_i;
  logic            queue_empty_i;
  logic [1:0]      log_type_i;
  logic [XLEN-1:0] log_pc_i;
  logic [XLEN-1:0] log_target_i;
  logic            log_compressed_i;
  logic            queue_pop_o;
  logic            fault_valid_o;
  logic [1:0]      fault_cause_o;
  logic [XLEN-1:0] fault_tval_o;
  logic            fault_clear_i;
  logic [SW-1:0]   stack_level_o;

  entry_t logq[$];
  exp_t   exp_q[$];
  int     vectors;
  int     miscompares;

  cfi_shadow_stack_backend #(.XLEN(XLEN), .STACK_DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .queue_empty_i    (queue_empty_i),
    .log_type_i       (log_type_i),
    .log_pc_i         (log_pc_i),
    .log_target_i     (log_target_i),
    .log_compressed_i (log_compressed_i),
    .queue_pop_o      (queue_pop_o),
    .fault_valid_o    (fault_valid_o),
    .fault_cause_o    (fault_cause_o),
    .fault_tval_o     (fault_tval_o),
    .fault_clear_i    (fault_clear_i),
    .stack_level_o    (stack_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO head presentation plus spec rules on a queue stack.
  initial begin
    logic [XLEN-1:0] m_stack[$];
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] top;
    logic            m_fault;
    logic [1:0]      m_cause;
    logic [XLEN-1:0] m_tval;
    bit              inflight, stage, rst_prev, clr_prev, started, exp_pop;
    entry_t          cur;
    m_fault = 0; m_cause = 0; m_tval = 0;
    inflight = 0; stage = 0; rst_prev = 0; clr_prev = 0; started = 0;
    queue_empty_i = 1'b1; log_type_i = '0; log_pc_i = '0; log_target_i = '0;
    log_compressed_i = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (logq.size() > 0) begin
        queue_empty_i    = 1'b0;
        log_type_i       = logq[0].typ;
        log_pc_i         = logq[0].pc;
        log_target_i     = logq[0].target;
        log_compressed_i = logq[0].comp;
      end else begin
        queue_empty_i    = 1'b1;
        log_type_i       = '0;
        log_pc_i         = '0;
        log_target_i     = '0;
        log_compressed_i = 1'b0;
      end
      #1;
      if (rst_prev) begin
        m_stack = {}; m_fault = 0; m_cause = 0; m_tval = 0;
        inflight = 0; started = 1;
      end else begin
        if (m_fault && clr_prev) begin
          m_stack = {}; m_fault = 0; m_cause = 0; m_tval = 0;
        end
        if (inflight) begin
          if (stage) begin
            inflight = 0;
            ra = cur.pc + (cur.comp ? 64'd2 : 64'd4);
            if (cur.typ == 2'b10) begin
              if (m_stack.size() == DEPTH) begin
                m_fault = 1; m_cause = 2'b11; m_tval = cur.pc;
              end else begin
                m_stack.push_back(ra);
              end
            end else if (cur.typ == 2'b11) begin
              if (m_stack.size() == 0) begin
                m_fault = 1; m_cause = 2'b10; m_tval = cur.pc;
              end else begin
                top = m_stack.pop_back();
                if (top !== cur.target) begin
                  m_fault = 1; m_cause = 2'b01; m_tval = cur.pc;
                end
              end
            end
          end else begin
            stage = 1;
          end
        end
      end
      exp_pop = started && !rst_i && !m_fault && !inflight && (logq.size() > 0);
      if (started) exp_q.push_back('{exp_pop, m_fault, m_cause, m_tval, SW'(m_stack.size())});
      if (exp_pop) begin
        cur = logq[0]; inflight = 1; stage = 0;
      end
      if (queue_pop_o === 1'b1 && logq.size() > 0) void'(logq.pop_front());
      rst_prev = rst_i;
      clr_prev = fault_clear_i;
    end
  end

  // Monitor: compares DUT outputs against each scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (queue_pop_o !== e.pop) begin
          miscompares++;
          $display("FAIL pop @%0t: got %b want %b", $time, queue_pop_o, e.pop);
        end
        if (fault_valid_o !== e.valid) begin
          miscompares++;
          $display("FAIL valid @%0t: got %b want %b", $time, fault_valid_o, e.valid);
        end
        if (fault_cause_o !== e.cause) begin
          miscompares++;
          $display("FAIL cause @%0t: got %b want %b", $time, fault_cause_o, e.cause);
        end
        if (fault_tval_o !== e.tval) begin
          miscompares++;
          $display("FAIL tval @%0t: got %h want %h", $time, fault_tval_o, e.tval);
        end
        if (stack_level_o !== e.level) begin
          miscompares++;
          $display("FAIL level @%0t: got %0d want %0d", $time, stack_level_o, e.level);
        end
      end
    end
  end

  task automatic push(input logic [1:0] t, input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] tgt, input logic c);
    entry_t e;
    e.typ = t; e.pc = pc; e.target = tgt; e.comp = c;
    logq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, want);
    end
  endtask

  // Wait until the FIFO drains or a fault stops it, then let the last entry finish.
  task automatic settle(input int budget);
    int n;
    n = 0;
    while (logq.size() != 0 && fault_valid_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL settle timeout @%0t: got %0d entries left want 0", $time, logq.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_fault();
    @(negedge clk);
    fault_clear_i = 1'b1;
    @(negedge clk);
    fault_clear_i = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] drv[$];
    logic [XLEN-1:0] pc, tgt;
    logic [1:0]      t;
    logic            c;
    int              n;
    vectors = 0; miscompares = 0;
    rst_i = 1'b1; fault_clear_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #4;
    chk("reset_level", 64'(stack_level_o), 64'd0);
    chk("reset_valid", 64'(fault_valid_o), 64'd0);
    chk("reset_cause", 64'(fault_cause_o), 64'd0);
    chk("reset_tval", fault_tval_o, 64'd0);
    chk("reset_pop", 64'(queue_pop_o), 64'd0);

    // Call then matching return.
    @(negedge clk);
    push(2'b10, 64'h8000_1000, 64'h8000_2222, 1'b0);
    push(2'b11, 64'h8000_1100, 64'h8000_1004, 1'b0);
    settle(50); #4;
    chk("t1_level", 64'(stack_level_o), 64'd0);
    chk("t1_valid", 64'(fault_valid_o), 64'd0);

    // Compressed call, mismatching return, then a queued branch held back.
    @(negedge clk);
    push(2'b10, 64'h8000_2000, 64'h0, 1'b1);
    push(2'b11, 64'h8000_3000, 64'h8000_2004, 1'b0);
    push(2'b00, 64'h8000_3004, 64'h8000_3100, 1'b0);
    settle(50); #4;
    chk("t2_valid", 64'(fault_valid_o), 64'd1);
    chk("t2_cause", 64'(fault_cause_o), 64'd1);
    chk("t2_tval", fault_tval_o, 64'h8000_3000);
    chk("t2_level", 64'(stack_level_o), 64'd0);
    repeat (5) @(negedge clk);
    #4 chk("t2_held", 64'(logq.size()), 64'd1);
    clear_fault();
    settle(50); #4;
    chk("t2_clear_valid", 64'(fault_valid_o), 64'd0);

    // Return on an empty stack.
    @(negedge clk);
    push(2'b11, 64'h8000_0100, 64'h1234, 1'b0);
    push(2'b01, 64'h8000_0200, 64'h8000_0300, 1'b0);
    settle(50); #4;
    chk("t3_cause", 64'(fault_cause_o), 64'd2);
    chk("t3_tval", fault_tval_o, 64'h8000_0100);
    clear_fault();
    settle(50); #4;
    chk("t3_clear_valid", 64'(fault_valid_o), 64'd0);
    chk("t3_drained", 64'(logq.size()), 64'd0);

    // Overflow at the default depth.
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push(2'b10, 64'h8000_4000 + 64'(4 * i), 64'h0, 1'b0);
    settle(100); #4;
    chk("t4_full", 64'(stack_level_o), 64'd16);
    push(2'b10, 64'h8000_4040, 64'h0, 1'b0);
    settle(50); #4;
    chk("t4_cause", 64'(fault_cause_o), 64'd3);
    chk("t4_tval", fault_tval_o, 64'h8000_4040);
    chk("t4_level", 64'(stack_level_o), 64'd16);
    clear_fault();
    #4 chk("t4_clear_level", 64'(stack_level_o), 64'd0);

    // Back-to-back branches and jumps.
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(2'(i % 2), 64'h8000_5000 + 64'(8 * i), 64'h9000, 1'b0);
    settle(60); #4;
    chk("t5_level", 64'(stack_level_o), 64'd0);
    chk("t5_valid", 64'(fault_valid_o), 64'd0);

    // Reset during EXEC of a call with three entries stacked.
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(2'b10, 64'h8000_6000 + 64'(4 * i), 64'h0, 1'b0);
    settle(50); #4;
    chk("t6_level3", 64'(stack_level_o), 64'd3);
    push(2'b10, 64'h8000_6100, 64'h0, 1'b0);
    n = 0;
    do begin
      @(negedge clk); #3; n++;
    end while (queue_pop_o !== 1'b1 && n < 20);
    chk("t6_pop_seen", 64'(queue_pop_o), 64'd1);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #4;
    chk("t6_rst_level", 64'(stack_level_o), 64'd0);
    chk("t6_rst_valid", 64'(fault_valid_o), 64'd0);
    chk("t6_rst_pop", 64'(queue_pop_o), 64'd0);
    // Reset during FAULT.
    @(negedge clk);
    push(2'b11, 64'h8000_0200, 64'h0, 1'b0);
    settle(50); #4;
    chk("t6_fault", 64'(fault_valid_o), 64'd1);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #4;
    chk("t6_frst_valid", 64'(fault_valid_o), 64'd0);
    chk("t6_frst_cause", 64'(fault_cause_o), 64'd0);
    chk("t6_frst_tval", fault_tval_o, 64'd0);

    // Randomized bursts, mostly well-nested with occasional corruption.
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      n = 1 + int'($urandom_range(0, 5));
      for (int k = 0; k < n; k++) begin
        t   = 2'($urandom_range(0, 3));
        c   = 1'($urandom_range(0, 1));
        pc  = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tgt = {$urandom, $urandom};
        if (t == 2'b10) begin
          drv.push_back(pc + (c ? 64'd2 : 64'd4));
        end else if (t == 2'b11 && drv.size() > 0) begin
          tgt = drv.pop_back();
          if ($urandom_range(0, 9) == 0) tgt = tgt ^ 64'h10;
        end
        push(t, pc, tgt, c);
      end
      settle(200);
      if (fault_valid_o === 1'b1) begin
        clear_fault();
        drv = {};
      end
    end
    settle(200);
    if (fault_valid_o === 1'b1) clear_fault();
    repeat (3) @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
